video_sync_decoder: RTL and testbench



---
 rtl/video_timing_pkg.sv | 30 +++
 rtl/sync_edge_detect.sv | 32 +++
 rtl/video_sync_decoder.sv | 152 +++++++++++++++
 tb/tb_video_sync_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared video timing constants, decoder state enum and pixel colour type
// Imported by the generator and by video_sync_decoder so both sides agree on one raster.
package video_timing_pkg;

  localparam int H_DISPLAY    = 256;
  localparam int H_FRONT      = 7;
  localparam int H_SYNC       = 23;
  localparam int H_BACK       = 23;
  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;

  localparam int V_DISPLAY    = 240;
  localparam int V_BOTTOM     = 14;
  localparam int V_SYNC       = 3;
  localparam int V_TOP        = 5;
  localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;

  localparam int LOCK_FRAMES  = 2;
  localparam int LOSS_LINES   = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

  typedef logic [2:0] rgb_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - rising-edge detector for one sync line with optional high-sample qualification
// Ports: clk, reset (sync, active-high), sig (raw sync input), edge_pulse (combinational, high on the
//        sample where sig has been high for exactly DEPTH consecutive samples).
module sync_edge_detect #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic edge_pulse
);

  logic [DEPTH-1:0] hist;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) hist <= 1'b0;
        else       hist <= sig;
      end
      assign edge_pulse = sig & ~hist[0];
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) hist <= '0;
        else       hist <= {hist[DEPTH-2:0], sig};
      end
      // Current and the DEPTH-1 previous samples high, the one before that low.
      assign edge_pulse = sig & (&hist[DEPTH-2:0]) & ~hist[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_sync_decoder.sv
// rtl/video_sync_decoder.sv - recovers pixel position, display enable and lock from hsync/vsync/rgb
// Optional feature macro: SYNC_GLITCH_FILTER_EN (sync edges need two consecutive high samples).
// Ports: clk, reset (sync, active-high); hsync, vsync, rgb[2:0] inputs;
//        hpos[8:0], vpos[8:0], display_on, rgb_out[2:0], locked, frame_done outputs,
//        all registered and describing the input sample of the previous cycle.
module video_sync_decoder #(
  parameter int H_DISPLAY   = video_timing_pkg::H_DISPLAY,
  parameter int H_FRONT     = video_timing_pkg::H_FRONT,
  parameter int H_SYNC      = video_timing_pkg::H_SYNC,
  parameter int H_BACK      = video_timing_pkg::H_BACK,
  parameter int V_DISPLAY   = video_timing_pkg::V_DISPLAY,
  parameter int V_BOTTOM    = video_timing_pkg::V_BOTTOM,
  parameter int V_SYNC      = video_timing_pkg::V_SYNC,
  parameter int V_TOP       = video_timing_pkg::V_TOP,
  parameter int LOCK_FRAMES = video_timing_pkg::LOCK_FRAMES,
  parameter int LOSS_LINES  = video_timing_pkg::LOSS_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       display_on,
  output logic [2:0] rgb_out,
  output logic       locked,
  output logic       frame_done
);

  import video_timing_pkg::*;

`ifdef SYNC_GLITCH_FILTER_EN
  // A qualified edge is seen one sample after the sync rise, so it marks H_SYNC_START+1.
  localparam int EDGE_DEPTH = 2;
  localparam int EDGE_SKEW  = 1;
`else
  localparam int EDGE_DEPTH = 1;
  localparam int EDGE_SKEW  = 0;
`endif

  localparam int         H_TOTAL_I = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int         V_TOTAL_I = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam logic [8:0] H_LAST    = 9'(H_TOTAL_I - 1);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL_I - 1);
  localparam logic [8:0] H_EDGE    = 9'(H_DISPLAY + H_FRONT + EDGE_SKEW);
  localparam logic [8:0] V_EDGE    = 9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] H_VIS     = 9'(H_DISPLAY);
  localparam logic [8:0] V_VIS     = 9'(V_DISPLAY);
  localparam logic [7:0] LOCK_N    = 8'(LOCK_FRAMES);
  localparam logic [7:0] LOSS_N    = 8'(LOSS_LINES);

  logic        hs_edge, vs_edge;
  logic [8:0]  hcnt, vcnt;
  logic [8:0]  pos_h, pos_v, nxt_h, nxt_v;
  logic        h_wrap, at_check;
  logic        line_good, line_bad, frame_bad;
  logic        gain_lock, drop_lock, lock_next;
  logic [7:0]  frame_cnt, miss_cnt;
  sync_state_t state;

  sync_edge_detect #(.DEPTH(EDGE_DEPTH)) u_hs_edge (
    .clk       (clk),
    .reset     (reset),
    .sig       (hsync),
    .edge_pulse(hs_edge)
  );

  sync_edge_detect #(.DEPTH(EDGE_DEPTH)) u_vs_edge (
    .clk       (clk),
    .reset     (reset),
    .sig       (vsync),
    .edge_pulse(vs_edge)
  );

  always_comb begin
    // hcnt/vcnt hold the predicted position of the current sample; edges override it.
    pos_h    = hs_edge ? H_EDGE : hcnt;
    pos_v    = vs_edge ? V_EDGE : vcnt;
    h_wrap   = (pos_h == H_LAST);
    nxt_h    = h_wrap ? 9'd0 : pos_h + 9'd1;
    // A vertical edge pins the line even if the same sample ends a line.
    if (vs_edge)     nxt_v = V_EDGE;
    else if (h_wrap) nxt_v = (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
    else             nxt_v = vcnt;

    // One check per line: an edge exactly at the expected spot is good; an edge
    // elsewhere or the expected spot passing without an edge is bad.
    at_check  = (hcnt == H_EDGE);
    line_good = hs_edge & at_check;
    line_bad  = hs_edge ^ at_check;
    frame_bad = vs_edge & (vcnt != V_EDGE);

    gain_lock = (state == ACQUIRE) & ~line_bad & ~frame_bad & vs_edge &
                (frame_cnt + 8'd1 == LOCK_N);
    drop_lock = (state == LOCKED) &
                (frame_bad | (line_bad & (miss_cnt + 8'd1 == LOSS_N)));
    lock_next = ((state == LOCKED) & ~drop_lock) | gain_lock;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      frame_cnt  <= 8'd0;
      miss_cnt   <= 8'd0;
      hcnt       <= 9'd0;
      vcnt       <= 9'd0;
      hpos       <= 9'd0;
      vpos       <= 9'd0;
      rgb_out    <= 3'd0;
      display_on <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hcnt       <= nxt_h;
      vcnt       <= nxt_v;
      hpos       <= pos_h;
      vpos       <= pos_v;
      rgb_out    <= rgb_t'(rgb);
      locked     <= lock_next;
      display_on <= lock_next & (pos_h < H_VIS) & (pos_v < V_VIS);
      // vpos still holds the previous sample's line here.
      frame_done <= lock_next & (pos_v == 9'd0) & (vpos == V_LAST);

      unique case (state)
        SEARCH: begin
          if (vs_edge) begin
            state     <= ACQUIRE;
            frame_cnt <= 8'd0;
          end
        end
        ACQUIRE: begin
          if (line_bad || frame_bad) begin
            state <= SEARCH;
          end else if (gain_lock) begin
            state    <= LOCKED;
            miss_cnt <= 8'd0;
          end else if (vs_edge) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        LOCKED: begin
          if (drop_lock)      state    <= SEARCH;
          else if (line_bad)  miss_cnt <= miss_cnt + 8'd1;
          else if (line_good) miss_cnt <= 8'd0;
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_video_sync_decoder.sv
// tb/tb_video_sync_decoder.sv - self-checking bench for video_sync_decoder on a reduced raster
module tb_video_sync_decoder;
  import video_timing_pkg::*;

  localparam int HD = 16, HF = 3, HSW = 4, HB = 5;
  localparam int VD = 12, VB = 3, VSW = 2, VTP = 3;
  localparam int HT = HD + HF + HSW + HB;
  localparam int VTOT = VD + VB + VSW + VTP;
  localparam int HSS = HD + HF;
  localparam int VSS = VD + VB;
  localparam int LOCKF = 2, LOSSL = 4;
  localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCK = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b0, vsync = 1'b0;
  rgb_t       rgb = 3'd0;
  logic [8:0] hpos, vpos;
  logic       display_on, locked, frame_done;
  logic [2:0] rgb_out;

  video_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VTP),
    .LOCK_FRAMES(LOCKF), .LOSS_LINES(LOSSL)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .rgb_out(rgb_out),
    .locked(locked), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  bit cmp_en = 0;

  int gh = 0, gv = 0, last_gh = 0, last_gv = 0, rises = 0;
  bit last_rise = 0, prev_vs = 0;

  // Model state: linear raster index of the predicted current sample, lock bookkeeping.
  int m_p = 0, m_st = M_SEARCH, m_fc = 0, m_mc = 0;
  bit m_hq = 0, m_vq = 0;
  logic [8:0] e_hpos = 0, e_vpos = 0;
  logic [2:0] e_rgb = 0;
  logic       e_disp = 0, e_lock = 0, e_fd = 0;

  task automatic model_step(input bit rst, input bit hs, input bit vs, input rgb_t c);
    int h, v, ch, cv;
    bit he, ve, lgood, lbad, fbad, lk;
    if (rst) begin
      m_p = 0; m_hq = 0; m_vq = 0; m_st = M_SEARCH; m_fc = 0; m_mc = 0;
      e_hpos = 0; e_vpos = 0; e_rgb = 0; e_disp = 0; e_lock = 0; e_fd = 0;
      return;
    end
    he = hs && !m_hq;
    ve = vs && !m_vq;
    h = m_p % HT;
    v = m_p / HT;
    lgood = he && (h == HSS);
    lbad  = (he && h != HSS) || (!he && h == HSS);
    fbad  = ve && (v != VSS);
    ch = he ? HSS : h;
    cv = ve ? VSS : v;
    case (m_st)
      M_SEARCH: if (ve) begin m_st = M_ACQ; m_fc = 0; end
      M_ACQ: begin
        if (lbad || fbad) m_st = M_SEARCH;
        else if (ve) begin
          m_fc++;
          if (m_fc == LOCKF) begin m_st = M_LOCK; m_mc = 0; end
        end
      end
      default: begin
        if (fbad) m_st = M_SEARCH;
        else if (lbad) begin
          m_mc++;
          if (m_mc == LOSSL) m_st = M_SEARCH;
        end else if (lgood) m_mc = 0;
      end
    endcase
    lk = (m_st == M_LOCK);
    e_fd   = lk && (cv == 0) && (e_vpos == 9'(VTOT - 1));
    e_hpos = 9'(ch);
    e_vpos = 9'(cv);
    e_rgb  = c;
    e_lock = lk;
    e_disp = lk && (ch < HD) && (cv < VD);
    m_p = ve ? (VSS * HT + (ch + 1) % HT) : ((cv * HT + ch + 1) % (HT * VTOT));
    m_hq = hs;
    m_vq = vs;
  endtask

  // hm/vm: 0 = generator waveform, 1 = force high, 2 = force low. cf < 0 = random colour.
  task automatic cycle(input bit rst, input bit grst, input int hm, input int vm, input int cf);
    bit hs, vs;
    rgb_t c;
    @(negedge clk); #1;
    hs = (hm == 0) ? (gh >= HSS && gh < HSS + HSW) : (hm == 1);
    vs = (vm == 0) ? (gv >= VSS && gv < VSS + VSW) : (vm == 1);
    c  = (cf < 0) ? rgb_t'($urandom_range(7)) : rgb_t'(cf);
    reset = rst; hsync = hs; vsync = vs; rgb = c;
    last_rise = !rst && vs && !prev_vs;
    if (last_rise) rises++;
    prev_vs = rst ? 1'b0 : vs;
    last_gh = gh; last_gv = gv;
    model_step(rst, hs, vs, c);
    if (grst) begin
      gh = 0; gv = 0;
    end else begin
      gh++;
      if (gh == HT) begin gh = 0; gv = (gv + 1) % VTOT; end
    end
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic run_to(input int v, input int h);
    int n = 0;
    while (!(gv == v && gh == h) && n < HT * VTOT + 1) begin
      cycle(0, 0, 0, 0, -1);
      n++;
    end
  endtask

  task automatic run_until_locked(input string nm, input int max_cyc);
    int n = 0;
    while (locked !== 1'b1 && n < max_cyc) begin
      cycle(0, 0, 0, 0, -1);
      n++;
    end
    vectors++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL %s: locked=%b after %0d cycles, expected 1", nm, locked, n);
    end
  endtask

  task automatic check_zero(input string nm);
    lit({nm, "_hpos"}, hpos, 0);
    lit({nm, "_vpos"}, vpos, 0);
    lit({nm, "_rgb_out"}, rgb_out, 0);
    lit({nm, "_display_on"}, display_on, 0);
    lit({nm, "_locked"}, locked, 0);
    lit({nm, "_frame_done"}, frame_done, 0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (hpos !== e_hpos || vpos !== e_vpos || rgb_out !== e_rgb ||
          display_on !== e_disp || locked !== e_lock || frame_done !== e_fd) begin
        errors++;
        $display("FAIL model_cmp t=%0t: dut h=%0d v=%0d rgb=%0d de=%b lk=%b fd=%b, expected h=%0d v=%0d rgb=%0d de=%b lk=%b fd=%b",
                 $time, hpos, vpos, rgb_out, display_on, locked, frame_done,
                 e_hpos, e_vpos, e_rgb, e_disp, e_lock, e_fd);
      end
    end
  end

  initial begin
    int drop_v, drop_h;

    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, -1);
    cmp_en = 1;
    check_zero("reset");

    rises = 0;
    run_until_locked("initial_lock", 4 * HT * VTOT);
    lit("lock_on_vsync_rise_cycle", last_rise, 1);
    lit("rises_to_lock", rises, 3);

    run_to(5, 10);
    cycle(0, 0, 0, 0, 5);
    lit("rgb_align_rgb_out", rgb_out, 5);
    lit("rgb_align_hpos", hpos, 10);
    lit("rgb_align_vpos", vpos, 5);
    lit("rgb_align_display_on", display_on, 1);

    run_to(0, 0);
    cycle(0, 0, 0, 0, -1);
    lit("frame_done_pulse", frame_done, 1);
    cycle(0, 0, 0, 0, -1);
    lit("frame_done_single", frame_done, 0);

    run_to(2, 0);
    rises = 0;
    drop_v = -1; drop_h = -1;
    for (int i = 0; i < 4 * HT; i++) begin
      cycle(0, 0, 2, 0, -1);
      if (locked === 1'b0 && drop_v < 0) begin drop_v = last_gv; drop_h = last_gh; end
    end
    lit("hs_loss_drop_line", drop_v, 5);
    lit("hs_loss_drop_pixel", drop_h, HSS);
    run_until_locked("relock_after_hs_loss", 4 * HT * VTOT);
    lit("relock_rises", rises, 3);

    run_to(VSS - 3, 5);
    cycle(0, 0, 0, 1, -1);
    lit("early_vsync_locked", locked, 0);
    lit("early_vsync_vpos", vpos, VSS);
    run_until_locked("relock_after_early_vsync", 4 * HT * VTOT);

    run_to(5, 8);
    cycle(0, 0, 1, 0, -1);
    lit("glitch_hpos", hpos, HSS);
    lit("glitch_locked", locked, 1);
    cycle(0, 0, 0, 0, -1);
    lit("glitch_hpos_next", hpos, HSS + 1);
    for (int i = 0; i < 2 * HT; i++) cycle(0, 0, 0, 0, -1);
    lit("glitch_lock_held", locked, 1);

    run_to(7, 10);
    cycle(1, 0, 0, 0, -1);
    check_zero("mid_reset");
    rises = 0;
    run_until_locked("relock_after_reset", 4 * HT * VTOT);
    lit("reset_relock_rises", rises, 3);

    for (int i = 0; i < 3000; i++) begin
      int hm, vm;
      hm = ($urandom_range(199) == 0) ? 1 : (($urandom_range(299) == 0) ? 2 : 0);
      vm = ($urandom_range(1999) == 0) ? 1 : 0;
      cycle(0, 0, hm, vm, -1);
    end

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
